// File: rtl/score_keeper_if.sv
// Signal bundle between the ball/match logic and the score keeper.
// The master drives the point and new-game pulses; the slave (score_keeper) drives score and serve state.
interface score_keeper_if;
    logic       p1_point;
    logic       p2_point;
    logic       new_game;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic       serve;
    logic       serve_dir;
    logic       game_active;

    modport master (
        output p1_point, p2_point, new_game,
        input  p1_score, p2_score, winner, serve, serve_dir, game_active
    );

    modport slave (
        input  p1_point, p2_point, new_game,
        output p1_score, p2_score, winner, serve, serve_dir, game_active
    );
endinterface

// File: rtl/score_keeper.sv
// Match scoring FSM: counts rally wins, detects the match winner and times the serve pulse.
// States are SERVE_WAIT (countdown to serve), PLAY (rally in progress) and GAME_OVER.
module score_keeper #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 25_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    score_keeper_if.slave sk
);

    localparam int unsigned    CW       = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SERVE_DELAY - 1);
    localparam logic [3:0]     WIN      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        SERVE_WAIT,
        PLAY,
        GAME_OVER
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    p1, p1_nx;
    logic [3:0]    p2, p2_nx;
    logic [1:0]    win, win_nx;
    logic          dir, dir_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SERVE_WAIT;
            cnt   <= CNT_LOAD;
            p1    <= '0;
            p2    <= '0;
            win   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            p1    <= p1_nx;
            p2    <= p2_nx;
            win   <= win_nx;
            dir   <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        p1_nx    = p1;
        p2_nx    = p2;
        win_nx   = win;
        dir_nx   = dir;

        case (state)
            SERVE_WAIT: begin
                if (cnt == '0) begin
                    state_nx = PLAY;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            PLAY: begin
                if (sk.p1_point && !sk.p2_point) begin
                    p1_nx  = p1 + 4'd1;
                    dir_nx = 1'b1;
                    if (p1 + 4'd1 == WIN) begin
                        state_nx = GAME_OVER;
                        win_nx   = 2'd1;
                    end else begin
                        state_nx = SERVE_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end else if (sk.p2_point && !sk.p1_point) begin
                    p2_nx  = p2 + 4'd1;
                    dir_nx = 1'b0;
                    if (p2 + 4'd1 == WIN) begin
                        state_nx = GAME_OVER;
                        win_nx   = 2'd2;
                    end else begin
                        state_nx = SERVE_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end else if (sk.p1_point && sk.p2_point) begin
                    // Simultaneous points: replay the rally without scoring.
                    state_nx = SERVE_WAIT;
                    cnt_nx   = CNT_LOAD;
                end
            end
            GAME_OVER: begin
                state_nx = GAME_OVER;
            end
            default: begin
                state_nx = SERVE_WAIT;
                cnt_nx   = CNT_LOAD;
            end
        endcase

        if (sk.new_game) begin
            state_nx = SERVE_WAIT;
            cnt_nx   = CNT_LOAD;
            p1_nx    = '0;
            p2_nx    = '0;
            win_nx   = '0;
            dir_nx   = 1'b0;
        end
    end

    assign sk.p1_score    = p1;
    assign sk.p2_score    = p2;
    assign sk.winner      = win;
    assign sk.serve_dir   = dir;
    assign sk.game_active = (state == PLAY);
    // Gated by reset_n so serve stays low while reset is held even when the counter loads zero.
    assign sk.serve       = reset_n && (state == SERVE_WAIT) && (cnt == '0);

    serve_single_pulse: assert property (
        @(posedge clk) disable iff (!reset_n) sk.serve |=> !sk.serve
    );

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper with WIN_SCORE=3, SERVE_DELAY=4.
// The reference model tracks scores and the edge at which the last serve countdown began.
module tb_score_keeper;

    localparam int WS = 3;
    localparam int SD = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    score_keeper_if sk ();

    score_keeper #(
        .WIN_SCORE   (WS),
        .SERVE_DELAY (SD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sk      (sk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ecount counts rising edges since reset release; m_start is the
    // edge count after which the current serve countdown began.
    int m_p1, m_p2, m_win, m_dir;
    bit m_over;
    int ecount, m_start;

    function automatic bit m_playing();
        return !m_over && (ecount - m_start >= SD);
    endfunction

    function automatic logic [12:0] m_vec();
        bit waiting;
        bit srv;
        bit act;
        waiting = !m_over && (ecount - m_start < SD);
        srv     = waiting && (ecount - m_start == SD - 1);
        act     = !m_over && !waiting;
        return {4'(m_p1), 4'(m_p2), 2'(m_win), srv, m_dir[0], act};
    endfunction

    function automatic logic [12:0] obs();
        return {sk.p1_score, sk.p2_score, sk.winner, sk.serve, sk.serve_dir, sk.game_active};
    endfunction

    task automatic m_reset();
        m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
        m_over = 0; ecount = 0; m_start = 0;
    endtask

    task automatic tick(input bit a, input bit b, input bit ng);
        bit playing;
        sk.p1_point = a;
        sk.p2_point = b;
        sk.new_game = ng;
        playing = m_playing();
        @(posedge clk);
        if (ng) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
            m_over = 0; m_start = ecount + 1;
        end else if (playing) begin
            if (a && !b) begin
                m_p1++; m_dir = 1;
                if (m_p1 == WS) begin m_over = 1; m_win = 1; end
                else m_start = ecount + 1;
            end else if (b && !a) begin
                m_p2++; m_dir = 0;
                if (m_p2 == WS) begin m_over = 1; m_win = 2; end
                else m_start = ecount + 1;
            end else if (a && b) begin
                m_start = ecount + 1;
            end
        end
        ecount++;
        #1;
        sk.p1_point = 1'b0;
        sk.p2_point = 1'b0;
        sk.new_game = 1'b0;
    endtask

    task automatic wait_play(input string tag);
        int guard;
        guard = 0;
        while (!m_playing() && guard < 3 * SD) begin
            tick(0, 0, 0);
            guard++;
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL %s_wait e%0d: got %h expected %h", tag, ecount, obs(), m_vec());
            end
        end
        if (!m_playing()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_wait_timeout: got not-playing expected playing", tag);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs(), 13'h0);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", obs(), 13'h0);
        end
        reset_n = 1'b1;
        m_reset();
    endtask

    task automatic test_first_serve();
        int serve_at;
        int serve_cnt;
        serve_at = -1;
        serve_cnt = 0;
        for (int i = 0; i < SD + 2; i++) begin
            tick(0, 0, 0);
            if (sk.serve === 1'b1) begin serve_at = ecount; serve_cnt++; end
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL first_serve e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
        n_checks++;
        if (serve_at != SD - 1 || serve_cnt != 1) begin
            n_fail++;
            $display("FAIL first_serve_time: got edge %0d count %0d expected edge %0d count 1",
                     serve_at, serve_cnt, SD - 1);
        end
    endtask

    task automatic test_p1_point();
        wait_play("p1_point");
        tick(1, 0, 0);
        n_checks++;
        if (obs() !== {4'd1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL p1_point_edge: got %h expected %h", obs(), {4'd1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0});
        end
        for (int i = 0; i < SD + 1; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL p1_point_serve e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
    endtask

    task automatic test_both_points();
        wait_play("both");
        tick(1, 1, 0);
        for (int i = 0; i < SD + 1; i++) begin
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL both_points e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_p2_win();
        for (int k = 0; k < WS; k++) begin
            wait_play("p2_win");
            tick(0, 1, 0);
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL p2_point%0d: got %h expected %h", k, obs(), m_vec());
            end
        end
        n_checks++;
        if (sk.p2_score !== 4'd3 || sk.winner !== 2'd2) begin
            n_fail++;
            $display("FAIL p2_win_edge: got score %0d winner %0d expected score 3 winner 2",
                     sk.p2_score, sk.winner);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            n_checks++;
            if (obs() !== m_vec() || sk.serve !== 1'b0) begin
                n_fail++;
                $display("FAIL game_over_hold e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
    endtask

    task automatic test_new_game_over();
        tick(1, 0, 1);
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL new_game_over: got %h expected %h", obs(), 13'h0);
        end
        for (int i = 0; i < SD + 1; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL new_game_serve e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
    endtask

    task automatic test_new_game_in_wait();
        int serve_after;
        serve_after = -1;
        wait_play("ng_wait");
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        for (int i = 1; i <= SD + 1; i++) begin
            tick(0, 0, 0);
            if (sk.serve === 1'b1 && serve_after < 0) serve_after = i;
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL ng_wait e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
        n_checks++;
        if (serve_after != SD - 1) begin
            n_fail++;
            $display("FAIL ng_wait_restart: got serve after %0d expected %0d", serve_after, SD - 1);
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 1);
        wait_play("rst_mid"); tick(1, 0, 0);
        wait_play("rst_mid"); tick(1, 0, 0);
        wait_play("rst_mid"); tick(0, 1, 0);
        tick(0, 0, 0);
        n_checks++;
        if (sk.p1_score !== 4'd2 || sk.p2_score !== 4'd1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got %0d/%0d expected 2/1", sk.p1_score, sk.p2_score);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %h expected %h", obs(), 13'h0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        for (int i = 0; i < SD + 1; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL rst_mid_serve e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
    endtask

    task automatic test_random();
        bit a, b, ng;
        for (int i = 0; i < 1500; i++) begin
            a  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 2) == 0);
            ng = ($urandom_range(0, 39) == 0);
            tick(a, b, ng);
            n_checks++;
            if (obs() !== m_vec()) begin
                n_fail++;
                $display("FAIL random e%0d: got %h expected %h", ecount, obs(), m_vec());
            end
        end
    endtask

    initial begin
        sk.p1_point = 1'b0;
        sk.p2_point = 1'b0;
        sk.new_game = 1'b0;
        m_reset();
        test_reset();
        test_first_serve();
        test_p1_point();
        test_both_points();
        test_p2_win();
        test_new_game_over();
        test_new_game_in_wait();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
